gf64_inv_power_seq: RTL and testbench
=====================================

Name: gf64_inv_power_seq

Overview:
- Sequential inverse of the GF(2^6) power-34 S-box.
- Computes y = x^13 in GF(2^6). Since 34·13 = 442 ≡ 1 (mod 63), x^13 undoes x^34 on every field element.
- Uses left-to-right square-and-multiply with a single time-shared GF(2^6) multiplier.
- Sits on the decryption/inverse path, behind a valid/ready handshake, and pairs with the combinational forward power-34 block.

Parameters:
- POLY, 7'b1000011, field reduction polynomial x^6+x+1. Elements are in polynomial basis, bit i = coefficient of x^i.
- EXP, 6'd13, exponent applied. Must be nonzero; the default is the inverse of 34 mod 63.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept an operand
- in_data  input  6  operand x
- out_valid  output  1  out_data holds a result
- out_ready  input  1  consumer accepts the result
- out_data  output  6  result x^EXP
- busy  output  1  FSM is not IDLE

Behaviour:
- Reset (asynchronous, active-high), all outputs immediately:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0.
  - Internal acc=0, xr=0, idx=5.
- Multiplier:
  - Single combinational GF(2^6) multiplier: 6x6 carry-less product reduced mod POLY.
  - Operand A=acc always. Operand B=acc in SQR, xr in MUL.
- States: IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: xr<=in_data, acc<=6'h01, idx<=5, go to SQR.
- SQR:
  - acc<=acc·acc.
  - If EXP[idx]=1, go to MUL.
  - Else if idx=0, go to DONE.
  - Else idx<=idx-1 and stay in SQR.
- MUL:
  - acc<=acc·xr.
  - If idx=0, go to DONE.
  - Else idx<=idx-1, go to SQR.
- DONE:
  - out_valid=1, out_data=acc.
  - On out_ready: go to IDLE, out_valid<=0.
- Latency:
  - Compute cycles = 6 + popcount(EXP); 9 for the default EXP.
  - out_valid rises 9 clock edges after the accept edge.
  - Latency is constant for all operands, including 0; no data-dependent early exit (no timing leak).
- Handshake:
  - in_ready=0 in SQR/MUL/DONE. in_valid there is ignored and in_data is not sampled.
  - No new operand is accepted in the same cycle a result is consumed. The next accept comes no earlier than the cycle after DONE→IDLE.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0, for any stall length.
  - out_ready while out_valid=0 has no effect.
- Boundaries:
  - x=0 → 0; x=1 → 1.
  - In DONE, in_valid=1 and out_ready=1 together: the result is consumed and the input is not accepted.
  - rst asserted mid-computation: the operation is aborted, no out_valid is produced, and all regs return to their reset values immediately.
- Arithmetic:
  - All values are 6-bit. Reduction folds product bits 10..6 using POLY[5:0].
  - No value above 6'h3F is ever stored.

Test Plan:
- Reset then x=6'h02 (alpha), out_ready=1:
  - out_valid rises exactly 9 edges after accept, with out_data=6'h0A (alpha^13).
  - Next cycle: in_ready=1, busy=0.
- Edge operands: x=6'h00 → 6'h00 and x=6'h01 → 6'h01, each with 9-cycle latency.
- Full sweep of all 64 x:
  - out_data matches a reference x^13 model.
  - Feeding out_data into the forward power-34 model returns x, all 64 round-trips.
  - The 64 outputs are distinct (bijection).
- Back-pressure:
  - x=6'h02, hold out_ready=0 for 20 cycles: out_valid=1 and out_data=6'h0A are stable throughout.
  - in_valid pulses during the stall are ignored.
  - out_ready=1 then completes the transfer.
- Reset mid-operation:
  - Assert rst 4 cycles after accepting x=6'h05: out_valid=0 and in_ready=1 immediately, with no stale result after release.
  - A fresh x=6'h02 then yields 6'h0A.
- Busy-input rejection: in_data toggles with in_valid=1 during SQR/MUL; the result equals the power of the originally accepted operand.

Source files
------------

// File: rtl/gf64_inv_power_seq_if.sv
// Valid/ready operand and result channels for the GF(2^6) x^EXP unit.
// The master drives operands and accepts results; the slave is the unit.
interface gf64_inv_power_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/gf64_inv_power_seq.sv
// Sequential GF(2^6) y = x^EXP (inverse of the power-34 S-box by default).
// Left-to-right square-and-multiply over one shared multiplier.
module gf64_inv_power_seq #(
  parameter logic [6:0] POLY = 7'b1000011,
  parameter logic [5:0] EXP  = 6'd13
) (
  input  logic clk,
  input  logic rst,
  gf64_inv_power_seq_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] acc_q, acc_d;
  logic [5:0] xr_q, xr_d;
  logic [2:0] idx_q, idx_d;
  logic [5:0] mul_b;
  logic [5:0] prod;

  function automatic logic [5:0] gf_mul(
    input logic [5:0] a,
    input logic [5:0] b
  );
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ ({5'b0, a} << i);
    end
    // Fold top bits down; POLY[6] clears the folded bit.
    if (p[10]) p = p ^ {POLY, 4'b0};
    if (p[9])  p = p ^ {1'b0, POLY, 3'b0};
    if (p[8])  p = p ^ {2'b0, POLY, 2'b0};
    if (p[7])  p = p ^ {3'b0, POLY, 1'b0};
    if (p[6])  p = p ^ {4'b0, POLY};
    return p[5:0];
  endfunction

  assign mul_b = (state_q == MUL) ? xr_q : acc_q;
  assign prod  = gf_mul(acc_q, mul_b);
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      xr_q    <= '0;
      idx_q   <= 3'd5;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      xr_q    <= xr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    xr_d          = xr_q;
    idx_d         = idx_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          xr_d    = bus.in_data;
          acc_d   = 6'h01;
          idx_d   = 3'd5;
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = prod;
        if (EXP[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == 3'd0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      MUL: begin
        acc_d = prod;
        if (idx_q == 3'd0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = SQR;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc_q;
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gf64_inv_power_seq.sv
// Directed bench for gf64_inv_power_seq: latency, handshake, reset
// abort and a full x^13 sweep against a log/antilog field model.
module tb_gf64_inv_power_seq;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  gf64_inv_power_seq_if bus ();

  gf64_inv_power_seq dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] exp_t [0:62];
  int         log_t [0:63];
  logic       seen  [0:63];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [5:0] xtime(input logic [5:0] v);
    return {v[4:0], 1'b0} ^ (v[5] ? 6'h03 : 6'h00);
  endfunction

  function automatic logic [5:0] gpow(input logic [5:0] x, input int e);
    if (x == 6'h00) return 6'h00;
    return exp_t[(e * log_t[x]) % 63];
  endfunction

  task automatic run_op(input logic [5:0] x, output logic [5:0] y,
                        output int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 6'h3F;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    y = bus.out_data;
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ov"}, bus.out_valid, 0);
    chk({tag, "_rdy"}, bus.in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [5:0] y;
  int         lat;

  initial begin
    exp_t[0] = 6'h01;
    for (int k = 1; k < 63; k++) exp_t[k] = xtime(exp_t[k-1]);
    for (int k = 0; k < 64; k++) log_t[k] = 0;
    for (int k = 0; k < 63; k++) log_t[exp_t[k]] = k;
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 6'h00;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_od", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed: a^13=0A, 0->0, 1->1, a^6=03 -> a^15=28, a^2=04 -> a^26=07
    run_op(6'h02, y, lat);
    chk("alpha_lat", 8'(lat), 9);
    chk("alpha_od", y, 8'h0A);
    consume("alpha");
    run_op(6'h00, y, lat);
    chk("zero_lat", 8'(lat), 9);
    chk("zero_od", y, 8'h00);
    consume("zero");
    run_op(6'h01, y, lat);
    chk("one_lat", 8'(lat), 9);
    chk("one_od", y, 8'h01);
    consume("one");
    run_op(6'h03, y, lat);
    chk("x03_od", y, 8'h28);
    consume("x03");
    run_op(6'h04, y, lat);
    chk("x04_od", y, 8'h07);
    consume("x04");

    // Back-pressure with ignored in_valid pulses
    bus.out_ready = 1'b0;
    run_op(6'h02, y, lat);
    chk("bp_lat", 8'(lat), 9);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 6'h15;
      @(posedge clk); #1;
      chk("bp_ov", bus.out_valid, 1);
      chk("bp_od", bus.out_data, 8'h0A);
      chk("bp_rdy", bus.in_ready, 0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h3F;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_done_ov", bus.out_valid, 0);
    chk("bp_done_busy", busy, 0);
    chk("bp_done_rdy", bus.in_ready, 1);

    // Reset mid-computation
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h05;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_ov", bus.out_valid, 0);
    chk("mrst_rdy", bus.in_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_od", bus.out_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("mrst_stale", bus.out_valid, 0);
    end
    run_op(6'h02, y, lat);
    chk("mrst_lat", 8'(lat), 9);
    chk("mrst_od2", y, 8'h0A);
    consume("mrst");

    // Busy-input rejection; DONE with in_valid&out_ready consumes only
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h02;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_data = 6'(lat * 7 + 1);
      @(posedge clk); #1;
      lat++;
    end
    chk("rej_lat", 8'(lat), 9);
    chk("rej_od", bus.out_data, 8'h0A);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rej_busy", busy, 0);
    chk("rej_rdy", bus.in_ready, 1);

    // Full sweep with round-trip and bijection checks
    for (int x = 0; x < 64; x++) begin
      run_op(6'(x), y, lat);
      chk("sw_lat", 8'(lat), 9);
      chk("sw_od", y, gpow(6'(x), 13));
      chk("sw_rt", gpow(y, 34), 8'(x));
      chk("sw_dist", seen[y], 0);
      seen[y] = 1'b1;
      consume("sw");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
